// File: rtl/bit_normalizer_if.sv
// Handshake and result bundle between a requester and the bit normalizer.
// The requester drives the enable/start/data; the normalizer returns the result and status.
interface bit_normalizer_if;
    logic        Module_Enable;
    logic        Start;
    logic [31:0] InputToNormalize;
    logic [7:0]  NormalizedOutput;
    logic [7:0]  ShiftNumber;
    logic        RightLeftShift_Flag;
    logic        Zero_Flag;
    logic        Busy;
    logic        Valid_Output;

    modport master (
        output Module_Enable, Start, InputToNormalize,
        input  NormalizedOutput, ShiftNumber, RightLeftShift_Flag, Zero_Flag, Busy, Valid_Output
    );

    modport slave (
        input  Module_Enable, Start, InputToNormalize,
        output NormalizedOutput, ShiftNumber, RightLeftShift_Flag, Zero_Flag, Busy, Valid_Output
    );
endinterface

// File: rtl/bit_normalizer.sv
// Reduces a 32-bit unsigned value to an 8-bit value with bit 7 set, one shift per clock,
// reporting shift count and direction so the companion shifter can rebuild the value.
module bit_normalizer (
    input  logic             Main_CLK,
    input  logic             Reset_n,
    bit_normalizer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] work;
    logic [7:0]  count;
    logic        right_mode;
    logic        zero_seen;
    logic        accept;
    logic        shift_end;

    assign accept    = bus.Module_Enable && bus.Start && ((state == IDLE) || (state == DONE));
    // Right mode stops once everything fits in the low byte; left mode once bit 7 is set.
    assign shift_end = (work == 32'd0) || (right_mode ? (work[31:8] == 24'd0) : work[7]);

    always_ff @(posedge Main_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!bus.Module_Enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.Start) state_next = SHIFT;
                SHIFT:   if (shift_end) state_next = DONE;
                DONE:    if (bus.Start) state_next = SHIFT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Main_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            work       <= 32'd0;
            count      <= 8'd0;
            right_mode <= 1'b0;
            zero_seen  <= 1'b0;
        end else if (!bus.Module_Enable) begin
            work       <= 32'd0;
            count      <= 8'd0;
            right_mode <= 1'b0;
            zero_seen  <= 1'b0;
        end else if (accept) begin
            work       <= bus.InputToNormalize;
            count      <= 8'd0;
            right_mode <= (bus.InputToNormalize[31:8] != 24'd0);
            zero_seen  <= 1'b0;
        end else if (state == SHIFT) begin
            if (!shift_end) begin
                work  <= right_mode ? {1'b0, work[31:1]} : {work[30:0], 1'b0};
                count <= count + 8'd1;
            end else if (work == 32'd0) begin
                zero_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.Busy                = (state == SHIFT);
        bus.Valid_Output        = (state == DONE);
        bus.NormalizedOutput    = (state == DONE) ? work[7:0] : 8'hFF;
        bus.ShiftNumber         = count;
        bus.RightLeftShift_Flag = right_mode;
        bus.Zero_Flag           = zero_seen;
    end

endmodule

// File: tb/tb_bit_normalizer.sv
// Directed plus randomized bench for bit_normalizer against an arithmetic reference model.
module tb_bit_normalizer;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    bit_normalizer_if bus();

    bit_normalizer dut (
        .Main_CLK (clk),
        .Reset_n  (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: locate the most significant set bit and derive the shift directly.
    task automatic model(input logic [31:0] x, output int n, output logic [7:0] out,
                         output logic dir, output logic zero);
        int p;
        p = -1;
        for (int i = 0; i < 32; i++) if (x[i]) p = i;
        zero = (x == 0);
        if (x == 0) begin
            n = 0; out = 8'h00; dir = 1'b0;
        end else if (p > 7) begin
            n = p - 7; out = 8'(x >> n); dir = 1'b1;
        end else begin
            n = 7 - p; out = 8'(x << n); dir = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.Valid_Output), 32'd0);
        check({tag, "_busy"},  32'(bus.Busy), 32'd0);
        check({tag, "_out"},   32'(bus.NormalizedOutput), 32'hFF);
        check({tag, "_cnt"},   32'(bus.ShiftNumber), 32'd0);
        check({tag, "_flags"}, {30'd0, bus.RightLeftShift_Flag, bus.Zero_Flag}, 32'd0);
    endtask

    // Called #1 after a clock edge. inject_at > 0 pulses Start with inject_val before that edge.
    task automatic run_op(input string tag, input logic [31:0] x,
                          input int inject_at, input logic [31:0] inject_val);
        int n;
        int cyc;
        logic [7:0] out;
        logic dir;
        logic zero;
        model(x, n, out, dir, zero);
        bus.Start = 1'b1;
        bus.InputToNormalize = x;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check({tag, "_busy_k"}, {30'd0, bus.Busy, bus.Valid_Output}, 32'd2);
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == inject_at) begin
                bus.Start = 1'b1;
                bus.InputToNormalize = inject_val;
            end
            @(posedge clk); #1;
            bus.Start = 1'b0;
            if (bus.Valid_Output) begin
                cyc = c;
                break;
            end
        end
        check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
        check({tag, "_out"},  32'(bus.NormalizedOutput), 32'(out));
        check({tag, "_cnt"},  32'(bus.ShiftNumber), 32'(n));
        check({tag, "_dir"},  32'(bus.RightLeftShift_Flag), 32'(dir));
        check({tag, "_zero"}, 32'(bus.Zero_Flag), 32'(zero));
        check({tag, "_busy_done"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        logic [31:0] x;
        passed = 0;
        total  = 0;
        rst_n = 1'b0;
        bus.Module_Enable = 1'b1;
        bus.Start = 1'b0;
        bus.InputToNormalize = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("idle");

        run_op("v80",   32'h0000_0080, 0, 0);
        run_op("v01",   32'h0000_0001, 0, 0);
        run_op("vmsb",  32'h8000_0000, 0, 0);
        run_op("v300",  32'h0000_0300, 0, 0);
        run_op("vzero", 32'h0000_0000, 0, 0);
        run_op("vall",  32'hFFFF_FFFF, 0, 0);
        run_op("vff",   32'h0000_00FF, 0, 0);
        run_op("v100",  32'h0000_0100, 0, 0);

        // Start during SHIFT must be ignored; this also restarts straight from DONE.
        run_op("ignore", 32'h0001_0000, 3, 32'h0000_0001);

        // Restart from DONE: Valid drops on the accepting edge.
        bus.Start = 1'b1;
        bus.InputToNormalize = 32'h0000_0040;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("restart_valid_drop", 32'(bus.Valid_Output), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("restart_out", 32'(bus.NormalizedOutput), 32'h80);

        // Asynchronous reset mid-SHIFT.
        bus.Start = 1'b1;
        bus.InputToNormalize = 32'h8000_0000;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 32'h0000_0300, 0, 0);

        // Enable low mid-SHIFT, then enable and Start together on one edge.
        bus.Start = 1'b1;
        bus.InputToNormalize = 32'h8000_0000;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.Module_Enable = 1'b0;
        @(posedge clk); #1;
        check_idle("abort_en");
        repeat (3) @(posedge clk);
        #1;
        check_idle("en_low_hold");
        bus.Module_Enable = 1'b1;
        run_op("en_start", 32'h0000_0001, 0, 0);

        for (int i = 0; i < 20; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            run_op($sformatf("rnd%0d", i), x, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
